dma_wr_arb: RTL and testbench

Arbiter and sequencer that shares one `dma_wr` write engine among `NUM_REQ` requesters. Each requester presents a write command (address, beat length) plus a data stream. The block grants one requester at a time, forwards its command to `dma_wr`, and muxes that requester's stream into `dma_wr` for exactly the commanded number of beats. It waits for `dma_wr` to drain (write response returned) before re-arbitrating, so each transfer is atomic on the AXI write channel.

---
 rtl/dma_wr_arb_pkg.sv | 36 +++
 rtl/dma_wr_arb_rr_arbiter.sv | 42 ++++
 rtl/dma_wr_arb.sv | 136 +++++++++++++
 tb/tb_dma_wr_arb.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_wr_arb_pkg.sv
// dma_wr_arb shared types: FSM state encoding and round-robin pick helper.
// Used by dma_wr_arb and rr_arbiter.
package dma_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  req,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  n
  );
    logic [MAX_ID_W-1:0] pick;
    logic                found;
    int                  idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req[idx]) begin
        pick  = MAX_ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dma_wr_arb_rr_arbiter.sv
// Round-robin pick with a registered search pointer.
// Compiled only when DMA_WR_ARB_RR_EN is defined.
`ifdef DMA_WR_ARB_RR_EN
module rr_arbiter
  import dma_wr_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  input  logic [ID_W-1:0] cur,
  output logic [ID_W-1:0] pick
);

  logic [ID_W-1:0]     ptr;
  logic [MAX_REQ-1:0]  req_w;
  logic [MAX_ID_W-1:0] ptr_w;
  logic [MAX_ID_W-1:0] pick_w;

  // Search starts at the pointer and wraps.
  always_comb begin
    req_w  = MAX_REQ'(req);
    ptr_w  = MAX_ID_W'(ptr);
    pick_w = rr_pick(req_w, ptr_w, N);
    pick   = ID_W'(pick_w);
  end

  // Pointer moves past the requester just serviced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      if (cur == ID_W'(N - 1)) ptr <= '0;
      else                     ptr <= cur + ID_W'(1);
    end
  end

endmodule
`endif

// File: rtl/dma_wr_arb.sv
// Shares one dma_wr engine among NUM_REQ requesters, one atomic transfer at a time.
// DMA_WR_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module dma_wr_arb
  import dma_wr_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int CONFIG_LEN_WIDTH = 9,
  parameter int ID_WIDTH         = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*CONFIG_LEN_WIDTH-1:0]  req_len,
  input  logic [NUM_REQ-1:0]                   s_valid,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]    s_data,
  output logic [NUM_REQ-1:0]                   s_ready,
  output logic                                 dma_config_valid,
  input  logic                                 dma_config_ready,
  output logic [AXI_ADDR_WIDTH-1:0]            dma_config_addr,
  output logic [CONFIG_LEN_WIDTH-1:0]          dma_config_len,
  input  logic                                 dma_config_empty,
  output logic                                 dma_valid_in,
  output logic [AXI_DATA_WIDTH-1:0]            dma_data_in,
  input  logic                                 dma_ready,
  output logic [ID_WIDTH-1:0]                  grant_id,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 zero_len_drop
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int LW = CONFIG_LEN_WIDTH;

  state_t              state;
  logic [LW-1:0]       cnt;
  logic [ID_WIDTH-1:0] pick;
  logic [AW-1:0]       cur_addr;
  logic [LW-1:0]       cur_len;
  logic [DW-1:0]       cur_data;
  logic                cfg_hs;
  logic                beat;

`ifdef DMA_WR_ARB_RR_EN
  logic advance;

  assign advance = done | zero_len_drop;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_WIDTH)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .cur     (grant_id),
    .pick    (pick)
  );
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) pick = ID_WIDTH'(i);
    end
  end
`endif

  // Slice out the granted requester's command and data.
  always_comb begin
    cur_addr = req_addr[int'(grant_id)*AW +: AW];
    cur_len  = req_len[int'(grant_id)*LW +: LW];
    cur_data = s_data[int'(grant_id)*DW +: DW];
  end

  // Command port, stream mux and status pulses, all gated by state.
  always_comb begin
    busy             = (state != IDLE);
    dma_config_valid = (state == CMD) && (cur_len != '0);
    dma_config_addr  = (state == CMD) ? cur_addr : '0;
    dma_config_len   = (state == CMD) ? cur_len : '0;
    cfg_hs           = dma_config_valid && dma_config_ready;
    zero_len_drop    = (state == CMD) && (cur_len == '0)
                     && req_valid[grant_id];
    req_ready        = '0;
    if (cfg_hs || zero_len_drop) req_ready[grant_id] = 1'b1;
    dma_valid_in     = (state == DATA) && s_valid[grant_id];
    dma_data_in      = (state == DATA) ? cur_data : '0;
    s_ready          = '0;
    if (state == DATA) s_ready[grant_id] = dma_ready;
    beat             = dma_valid_in && dma_ready;
    done             = (state == DRAIN) && dma_config_empty;
  end

  // Transfer sequencer: grant, command, count beats, wait for drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= pick;
            state    <= CMD;
          end
        end
        CMD: begin
          if (cfg_hs) begin
            cnt   <= cur_len;
            state <= DATA;
          end else if (zero_len_drop || !req_valid[grant_id]) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (beat) begin
            cnt <= cnt - LW'(1);
            if (cnt == LW'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dma_config_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_wr_arb.sv
// Scoreboard bench for dma_wr_arb: directed transfers, checked on handshakes.
// Expected grant order follows DMA_WR_ARB_RR_EN.
module tb_dma_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 9;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N-1:0]      s_valid;
  logic [N*DW-1:0]   s_data;
  logic [N-1:0]      s_ready;
  logic              dma_config_valid;
  logic              dma_config_ready;
  logic [AW-1:0]     dma_config_addr;
  logic [LW-1:0]     dma_config_len;
  logic              dma_config_empty;
  logic              dma_valid_in;
  logic [DW-1:0]     dma_data_in;
  logic              dma_ready;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              done;
  logic              zero_len_drop;

  dma_wr_arb #(
    .NUM_REQ          (N),
    .AXI_DATA_WIDTH   (DW),
    .AXI_ADDR_WIDTH   (AW),
    .CONFIG_LEN_WIDTH (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .dma_config_valid (dma_config_valid),
    .dma_config_ready (dma_config_ready),
    .dma_config_addr  (dma_config_addr),
    .dma_config_len   (dma_config_len),
    .dma_config_empty (dma_config_empty),
    .dma_valid_in     (dma_valid_in),
    .dma_data_in      (dma_data_in),
    .dma_ready        (dma_ready),
    .grant_id         (grant_id),
    .busy             (busy),
    .done             (done),
    .zero_len_drop    (zero_len_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } grant_t;

  grant_t        exp_g[$];
  logic [DW-1:0] exp_d[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int zero_cnt = 0;
  int cfg_cnt  = 0;
  int beat_cnt = 0;
  int leak_cnt = 0;
  int cur_id   = 0;
  int zero_id  = 3;
  bit abort    = 1'b0;
  bit tog      = 1'b0;

  function automatic logic [AW-1:0] addr_of(input int id, input int c);
    return AW'(32'h1000 * (id + 1) + c * 32'h100);
  endfunction

  function automatic logic [DW-1:0] data_of(input int id, input int c,
                                            input int b);
    return (DW'(id) << 24) | (DW'(c) << 16) | DW'(10 + b);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  task automatic expect_xfer(input int id, input int c, input int len);
    grant_t g;
    g.id   = id;
    g.addr = addr_of(id, c);
    g.len  = LW'(len);
    exp_g.push_back(g);
    for (int b = 0; b < len; b++) exp_d.push_back(data_of(id, c, b));
  endtask

  // Grant and data scoreboard, plus pulse counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dma_config_valid) cfg_cnt++;
      if (done) done_cnt++;
      if (zero_len_drop) begin
        zero_cnt++;
        chk("zero_req_ready", 64'(req_ready), 64'(N'(1) << zero_id));
      end
      if (dma_config_valid && dma_config_ready) begin
        if (exp_g.size() == 0) begin
          fail("grant_unexpected");
        end else begin
          grant_t g;
          g = exp_g.pop_front();
          cur_id = g.id;
          chk("grant_id", 64'(grant_id), 64'(g.id));
          chk("cfg_addr", 64'(dma_config_addr), 64'(g.addr));
          chk("cfg_len", 64'(dma_config_len), 64'(g.len));
          chk("cfg_req_ready", 64'(req_ready), 64'(N'(1) << g.id));
        end
      end
      if (dma_valid_in && dma_ready) begin
        beat_cnt++;
        if (exp_d.size() == 0) begin
          fail("data_unexpected");
        end else begin
          chk("beat_data", 64'(dma_data_in), 64'(exp_d.pop_front()));
          chk("beat_s_ready", 64'(s_ready), 64'(N'(1) << cur_id));
        end
      end
      if ((s_ready & ~(N'(1) << cur_id)) != '0) leak_cnt++;
    end
  end

  task automatic run_req(input int id, input int len, input int ncmd);
    int to;
    for (int c = 0; c < ncmd; c++) begin
      @(posedge clk);
      #1;
      if (abort) return;
      req_addr[id*AW +: AW] = addr_of(id, c);
      req_len[id*LW +: LW]  = LW'(len);
      req_valid[id]         = 1'b1;
      to = 0;
      while (!abort) begin
        @(negedge clk);
        if (req_ready[id]) break;
        to++;
        if (to > 500) begin
          fail("req_ready_timeout");
          req_valid[id] = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
      to = 0;
      for (int b = 0; b < len && !abort;) begin
        s_data[id*DW +: DW] = data_of(id, c, b);
        s_valid[id]         = 1'b1;
        @(negedge clk);
        if (s_ready[id]) b++;
        else if (++to > 500) begin
          fail("s_ready_timeout");
          s_valid[id] = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
      s_valid[id] = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input string nm);
    int to;
    to = 0;
    while (done_cnt < target) begin
      @(posedge clk);
      if (++to > 1000) begin
        fail(nm);
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    int z;
    int c0;
    int b0;
    int to;
    int bad_busy;
    int bad_cfg;
    int bad_srdy;
    rst_n            = 1'b0;
    req_valid        = '0;
    req_addr         = '0;
    req_len          = '0;
    s_valid          = '0;
    s_data           = '0;
    dma_config_ready = 1'b1;
    dma_config_empty = 1'b1;
    dma_ready        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_cfg_valid", 64'(dma_config_valid), 0);
    chk("rst_cfg_addr", 64'(dma_config_addr), 0);
    chk("rst_cfg_len", 64'(dma_config_len), 0);
    chk("rst_valid_in", 64'(dma_valid_in), 0);
    chk("rst_data_in", 64'(dma_data_in), 0);
    chk("rst_grant_id", 64'(grant_id), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_zero", 64'(zero_len_drop), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single transfer from requester 0.
    expect_xfer(0, 0, 4);
    d = done_cnt;
    run_req(0, 4, 1);
    wait_done(d + 1, "t1_done_timeout");
    @(negedge clk);
    chk("t1_beats_left", 64'(exp_d.size()), 0);
    chk("t1_idle", 64'(busy), 0);

    // Two competing requesters, two commands each.
`ifdef DMA_WR_ARB_RR_EN
    expect_xfer(1, 0, 3);
    expect_xfer(2, 0, 3);
    expect_xfer(1, 1, 3);
    expect_xfer(2, 1, 3);
`else
    expect_xfer(1, 0, 3);
    expect_xfer(1, 1, 3);
    expect_xfer(2, 0, 3);
    expect_xfer(2, 1, 3);
`endif
    d = done_cnt;
    fork
      run_req(1, 3, 2);
      run_req(2, 3, 2);
    join
    wait_done(d + 4, "t2_done_timeout");
    @(negedge clk);
    chk("t2_grants_left", 64'(exp_g.size()), 0);
    chk("t2_beats_left", 64'(exp_d.size()), 0);

    // Zero-length command from requester 3.
    zero_id = 3;
    z  = zero_cnt;
    c0 = cfg_cnt;
    run_req(3, 0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t3_zero_pulses", 64'(zero_cnt - z), 1);
    chk("t3_cfg_cycles", 64'(cfg_cnt - c0), 0);
    chk("t3_idle", 64'(busy), 0);

    // dma_ready toggling, len 8, requester 1 streams without a grant.
    expect_xfer(0, 0, 8);
    s_data[1*DW +: DW] = 32'hDEAD_BEEF;
    s_valid[1] = 1'b1;
    b0  = beat_cnt;
    d   = done_cnt;
    tog = 1'b1;
    fork
      begin
        run_req(0, 8, 1);
        tog = 1'b0;
      end
      begin
        while (tog) begin
          @(posedge clk);
          #1;
          dma_ready = ~dma_ready;
        end
      end
    join
    dma_ready  = 1'b1;
    s_valid[1] = 1'b0;
    wait_done(d + 1, "t4_done_timeout");
    chk("t4_beats", 64'(beat_cnt - b0), 8);
    chk("t4_beats_left", 64'(exp_d.size()), 0);

    // Long drain with a second request pending.
    dma_config_empty = 1'b0;
    expect_xfer(0, 0, 2);
    expect_xfer(1, 0, 2);
    b0 = beat_cnt;
    d  = done_cnt;
    fork
      run_req(0, 2, 1);
    join_none
    to = 0;
    while (beat_cnt < b0 + 2 && to < 200) begin
      @(posedge clk);
      to++;
    end
    if (beat_cnt < b0 + 2) fail("t5_beats_timeout");
    fork
      run_req(1, 2, 1);
    join_none
    bad_busy = 0;
    bad_cfg  = 0;
    bad_srdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b1) bad_busy++;
      if (dma_config_valid !== 1'b0) bad_cfg++;
      if (s_ready !== '0) bad_srdy++;
    end
    chk("t5_drain_busy", 64'(bad_busy), 0);
    chk("t5_drain_cfg", 64'(bad_cfg), 0);
    chk("t5_drain_s_ready", 64'(bad_srdy), 0);
    chk("t5_no_done", 64'(done_cnt - d), 0);
    @(posedge clk);
    #1;
    dma_config_empty = 1'b1;
    wait_done(d + 2, "t5_done_timeout");
    repeat (2) @(posedge clk);
    chk("t5_grants_left", 64'(exp_g.size()), 0);

    // Reset in the middle of a transfer.
    expect_xfer(0, 0, 6);
    b0 = beat_cnt;
    fork
      run_req(0, 6, 1);
    join_none
    to = 0;
    while (beat_cnt < b0 + 2 && to < 200) begin
      @(posedge clk);
      to++;
    end
    if (beat_cnt < b0 + 2) fail("t6_beats_timeout");
    #1;
    rst_n = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_grant_id", 64'(grant_id), 0);
    chk("t6_valid_in", 64'(dma_valid_in), 0);
    chk("t6_s_ready", 64'(s_ready), 0);
    chk("t6_cfg_valid", 64'(dma_config_valid), 0);
    exp_d.delete();
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    s_valid   = '0;
    abort     = 1'b0;
    rst_n     = 1'b1;
    expect_xfer(2, 0, 2);
    d = done_cnt;
    run_req(2, 2, 1);
    wait_done(d + 1, "t6_done_timeout");
    repeat (2) @(posedge clk);
    chk("t6_grants_left", 64'(exp_g.size()), 0);
    chk("t6_beats_left", 64'(exp_d.size()), 0);
    chk("s_ready_leak", 64'(leak_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
